// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock, so WIDTH/CHUNK cycles per operation.
// S, Cout and Ofl are registered and change only on the edge that finishes an operation.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ofl
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [IDXW-1:0]    r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ofl;
    logic               r_done;

    logic [CHUNK-1:0]   w_ca;
    logic [CHUNK-1:0]   w_cb;
    logic [CHUNK:0]     w_sum;
    logic [WIDTH-1:0]   w_fullSum;
    logic               w_last;
    logic               w_msbCarryIn;

    // Operands shift right each cycle, so the active chunk is always the low CHUNK bits;
    // the partial sum fills in from the top and is complete after the last chunk.
    assign w_ca         = r_a[CHUNK-1:0];
    assign w_cb         = r_b[CHUNK-1:0];
    assign w_sum        = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};
    assign w_fullSum    = (r_psum >> CHUNK) | (WIDTH'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign w_last       = (r_idx == IDXW'(N - 1));
    assign w_msbCarryIn = w_sum[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign S    = r_s;
    assign Cout = r_cout;
    assign Ofl  = r_ofl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (start)  w_nextState = RUN;
            RUN:  if (w_last) w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ofl   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= sub ? 1'b1 : Cin;
                        r_idx   <= '0;
                        r_psum  <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_sum[CHUNK];
                    r_psum  <= w_fullSum;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_s    <= w_fullSum;
                        r_cout <= w_sum[CHUNK];
                        r_ofl  <= w_sum[CHUNK] ^ w_msbCarryIn;
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: directed table, random ops against an arithmetic
// model, start-while-busy, back-to-back, mid-operation reset and the single-chunk configuration.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, Cin;
    logic [15:0] A, B;
    logic        busy, done, Cout, Ofl;
    logic [15:0] S;

    logic        start2, sub2, Cin2;
    logic [15:0] A2, B2;
    logic        busy2, done2, Cout2, Ofl2;
    logic [15:0] S2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .Ofl(Ofl)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(16)) dutWide (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .A(A2), .B(B2), .Cin(Cin2),
        .busy(busy2), .done(done2), .S(S2), .Cout(Cout2), .Ofl(Ofl2)
    );

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] expS;
        logic        expCout;
        logic        expOfl;
    } vec_t;

    // Returns {cout, ofl, sum} from plain 17-bit arithmetic and the sign rule for overflow.
    function automatic logic [17:0] refModel(input logic s, input logic [15:0] a, input logic [15:0] b,
                                             input logic c);
        logic [15:0] bb;
        logic [16:0] t;
        logic        ofl;
        bb  = s ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
        ofl = (a[15] == bb[15]) && (t[15] != a[15]);
        return {t[16], ofl, t[15:0]};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expS, input logic expCout,
                               input logic expOfl);
        checks++;
        if (S !== expS || Cout !== expCout || Ofl !== expOfl) begin
            errors++;
            $display("[TB] FAIL %s: got S=0x%04h Cout=%b Ofl=%b expected S=0x%04h Cout=%b Ofl=%b",
                     name, S, Cout, Ofl, expS, expCout, expOfl);
        end
    endtask

    // Caller is at a falling edge; the operation is sampled on the next rising edge.
    task automatic applyStimulus(input logic s, input logic [15:0] a, input logic [15:0] b,
                                 input logic c);
        sub   = s;
        A     = a;
        B     = b;
        Cin   = c;
        start = 1'b1;
    endtask

    // Called at a falling edge 'lat0' edges after the start edge; returns edges until done.
    task automatic waitDone(input int lat0, output int lat, output bit busyOk);
        lat    = lat0;
        busyOk = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) busyOk = 1'b0;
    endtask

    vec_t        vecs[8];
    int          lat;
    bit          busyOk;
    bit          sawDone;
    logic [17:0] r;
    logic        rs, rc;
    logic [15:0] ra, rb;

    initial begin
        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        start2 = 1'b0; sub2 = 1'b0; A2 = '0; B2 = '0; Cin2 = 1'b0;

        // Reset state, with start held high during reset to show it is ignored.
        @(negedge clk);
        applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0);
        repeat (2) @(negedge clk);
        checkVal("reset_busy", 32'(busy), 32'd0);
        checkVal("reset_done", 32'(done), 32'd0);
        checkOutput("reset_outputs", 16'h0000, 1'b0, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        sawDone = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checkVal("start_in_reset_ignored", 32'(sawDone), 32'd0);

        // Directed table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            start = 1'b0;
            waitDone(0, lat, busyOk);
            checkVal($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            checkVal($sformatf("vec%0d_busy", i), 32'(busyOk), 32'd1);
            checkOutput($sformatf("vec%0d_result", i), vecs[i].expS, vecs[i].expCout, vecs[i].expOfl);
            @(negedge clk);
            checkVal($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("vec%0d_hold", i), vecs[i].expS, vecs[i].expCout, vecs[i].expOfl);
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            r  = refModel(rs, ra, rb, rc);
            applyStimulus(rs, ra, rb, rc);
            @(negedge clk);
            start = 1'b0;
            waitDone(0, lat, busyOk);
            checkVal($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
            checkOutput($sformatf("rand%0d_result", i), r[15:0], r[17], r[16]);
            @(negedge clk);
        end

        // Start while busy is ignored; start in the done cycle is accepted back-to-back.
        applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        start = 1'b0;
        waitDone(2, lat, busyOk);
        checkVal("busy_start_latency", 32'(lat), 32'd4);
        checkOutput("busy_start_ignored", 16'h3333, 1'b0, 1'b0);
        r = refModel(1'b1, 16'h5000, 16'h0123, 1'b0);
        applyStimulus(1'b1, 16'h5000, 16'h0123, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_first_held", 16'h3333, 1'b0, 1'b0);
        waitDone(0, lat, busyOk);
        checkVal("b2b_latency", 32'(lat), 32'd4);
        checkVal("b2b_busy", 32'(busyOk), 32'd1);
        checkOutput("b2b_result", r[15:0], r[17], r[16]);
        @(negedge clk);

        // Asynchronous reset mid-operation clears outputs at once and suppresses done.
        applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("midrst_busy", 32'(busy), 32'd0);
        checkVal("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_outputs", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkVal("midrst_no_done", 32'(sawDone), 32'd0);
        applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        waitDone(0, lat, busyOk);
        checkVal("post_rst_latency", 32'(lat), 32'd4);
        checkOutput("post_rst_result", 16'h0100, 1'b0, 1'b0);

        // Single-chunk configuration: one add cycle.
        @(negedge clk);
        start2 = 1'b1; sub2 = 1'b0; A2 = 16'hFFFF; B2 = 16'hFFFF; Cin2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        checkVal("wide_busy", 32'(busy2), 32'd1);
        checkVal("wide_not_done_yet", 32'(done2), 32'd0);
        @(negedge clk);
        checkVal("wide_done", 32'(done2), 32'd1);
        checkVal("wide_busy_clear", 32'(busy2), 32'd0);
        checkVal("wide_result", {14'd0, Cout2, Ofl2, S2}, {14'd0, 1'b1, 1'b0, 16'hFFFE});
        @(negedge clk);
        checkVal("wide_done_pulse", 32'(done2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
